ahb_bus_master: RTL and testbench

Requesting-side AHB bus master engine: the counterpart of the system's request/grant arbiter. Accepts one transfer command (single or INCR burst of 32-bit words) from a local client and raises `hbusreq`. Once `hgrant` arrives it drives AHB address/data phases, streams write data in and read data out, and reports completion and error. Sits between a local DMA/CPU-port client and the shared AHB fabric, one instance per master index of the arbiter.

---
 rtl/ahb_bus_master_if.sv | 74 +++++++
 rtl/ahb_bus_master.sv | 237 +++++++++++++++++++++++
 tb/tb_ahb_bus_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bus_master_if.sv
// ---------------------------------------------------------------------------
// ahb_bus_master_if
// Bundles the local client command/data streams and the AHB master-side bus
// of one ahb_bus_master instance.
//   master modport : the engine (drives cmd_ready, wr_ready, rd_*, done/err,
//                    hbusreq and the AHB address/control/write-data outputs)
//   slave modport  : client + arbiter + AHB fabric side
// Signal groups:
//   cmd_*           : one-shot transfer command (valid/ready handshake)
//   wr_*            : write-beat stream into the engine
//   rd_valid/rd_data: read-beat pulses, no backpressure
//   done/err        : one-cycle completion pulse, err qualified by done
//   hbusreq/hgrant  : arbiter request/grant
//   h*              : AHB master outputs and slave response
// ---------------------------------------------------------------------------
interface ahb_bus_master_if #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ADDR_W    = 32
);
  localparam int unsigned LEN_W = $clog2(MAX_BEATS + 1);

  // Local client command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // Local client data streams
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_data;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              done;
  logic              err;

  // Arbiter handshake
  logic              hbusreq;
  logic              hgrant;

  // AHB master outputs
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [31:0]       hwdata;

  // AHB slave response
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  hgrant,
    input  hrdata, hready, hresp,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
    output hbusreq,
    output haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output hgrant,
    output hrdata, hready, hresp,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
    input  hbusreq,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_bus_master.sv
// ---------------------------------------------------------------------------
// ahb_bus_master
// Requesting-side AHB master engine. Takes one command (single or INCR burst
// of 32-bit words), requests the bus, and once granted issues address phases,
// streams write data out and read data back, then pulses done (with err if
// the slave answered ERROR).
// Ports:
//   hclk     : clock, rising edge
//   hresetn  : asynchronous active-low reset
//   bus      : ahb_bus_master_if.master (command, data streams, arbiter
//              handshake and AHB master bus)
// htrans and wr_ready are decoded combinationally from the current-cycle
// grant / wr_valid / hready / hresp so that an address phase can start in
// the first granted cycle and be cancelled in the first ERROR cycle.
// ---------------------------------------------------------------------------
module ahb_bus_master #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  ahb_bus_master_if.master     bus
);

  localparam int unsigned LEN_W = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;       // next address to issue
  logic [LEN_W-1:0]  beats_q,     beats_d;      // address phases still to issue
  logic              write_q,     write_d;
  logic              seq_ok_q,    seq_ok_d;     // previous cycle issued a beat
  logic              hold_q,      hold_d;       // issued beat stalled by hready=0
  logic              dp_pend_q,   dp_pend_d;    // a data phase is outstanding
  logic              dp_write_q,  dp_write_d;
  logic [31:0]       hwdata_q,    hwdata_d;
  logic              rd_valid_q,  rd_valid_d;
  logic [31:0]       rd_data_q,   rd_data_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              hbusreq_q,   hbusreq_d;

  logic              in_addr_state_c;
  logic              err_cancel_c;
  logic              issue_c;
  logic              accept_c;
  logic              dp_ok_c;
  logic              dp_err_c;
  logic [1:0]        htrans_c;
  logic [LEN_W-1:0]  len_c;

  // Command length: 0 means one beat, oversize clamps to MAX_BEATS
  always_comb begin
    len_c = bus.cmd_len;
    if (bus.cmd_len == '0) begin
      len_c = LEN_W'(1);
    end else if (bus.cmd_len > LEN_W'(MAX_BEATS)) begin
      len_c = LEN_W'(MAX_BEATS);
    end
  end

  assign in_addr_state_c = (state_q == S_REQ) || (state_q == S_XFER);

  // Any ERROR response on the outstanding data phase kills the pending beat
  assign err_cancel_c = dp_pend_q && bus.hresp;

  // A stalled beat must stay on the bus even if grant or wr_valid drops
  assign issue_c = in_addr_state_c && !err_cancel_c && (beats_q != '0) &&
                   (hold_q || (bus.hgrant && (!write_q || bus.wr_valid)));

  assign accept_c = issue_c && bus.hready;
  assign dp_ok_c  = dp_pend_q && bus.hready && !bus.hresp;
  assign dp_err_c = dp_pend_q && bus.hready && bus.hresp;

  // NONSEQ after a gap, on the first beat, and on every 1 KB boundary
  always_comb begin
    htrans_c = HTRANS_IDLE;
    if (issue_c) begin
      if (!seq_ok_q || (addr_q[9:0] == 10'd0)) begin
        htrans_c = HTRANS_NONSEQ;
      end else begin
        htrans_c = HTRANS_SEQ;
      end
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    write_d    = write_q;
    seq_ok_d   = seq_ok_q;
    hold_d     = hold_q;
    dp_pend_d  = dp_pend_q;
    dp_write_d = dp_write_q;
    hwdata_d   = hwdata_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    hbusreq_d  = hbusreq_q;

    // Retire the outstanding data phase
    if (dp_pend_q && bus.hready) begin
      dp_pend_d = 1'b0;
    end
    if (dp_ok_c && !dp_write_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.hrdata;
    end

    // Address phase bookkeeping; a new beat overrides the retire above
    if (in_addr_state_c) begin
      hold_d   = issue_c && !bus.hready;
      seq_ok_d = issue_c ? seq_ok_q : 1'b0;
      if (accept_c) begin
        addr_d     = addr_q + ADDR_W'(4);
        beats_d    = beats_q - LEN_W'(1);
        seq_ok_d   = 1'b1;
        dp_pend_d  = 1'b1;
        dp_write_d = write_q;
        if (write_q) begin
          hwdata_d = bus.wr_data;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = S_REQ;
          addr_d    = bus.cmd_addr & ~ADDR_W'(3);
          beats_d   = len_c;
          write_d   = bus.cmd_write;
          seq_ok_d  = 1'b0;
          hold_d    = 1'b0;
          hbusreq_d = 1'b1;
        end
      end
      S_REQ, S_XFER: begin
        if (dp_err_c) begin
          // Remaining beats are dropped
          state_d   = S_FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
          hbusreq_d = 1'b0;
          hold_d    = 1'b0;
        end else if (accept_c) begin
          if (beats_q == LEN_W'(1)) begin
            state_d   = S_DRAIN;
            hbusreq_d = 1'b0;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_DRAIN: begin
        if (dp_pend_q && bus.hready) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          err_d   = bus.hresp;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      write_q    <= 1'b0;
      seq_ok_q   <= 1'b0;
      hold_q     <= 1'b0;
      dp_pend_q  <= 1'b0;
      dp_write_q <= 1'b0;
      hwdata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hbusreq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      write_q    <= write_d;
      seq_ok_q   <= seq_ok_d;
      hold_q     <= hold_d;
      dp_pend_q  <= dp_pend_d;
      dp_write_q <= dp_write_d;
      hwdata_q   <= hwdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hbusreq_q  <= hbusreq_d;
    end
  end

  // Output drive
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = accept_c && write_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.hbusreq   = hbusreq_q;
  assign bus.haddr     = addr_q;
  assign bus.htrans    = htrans_c;
  assign bus.hwrite    = write_q;
  assign bus.hsize     = HSIZE_WORD;
  assign bus.hburst    = HBURST_INCR;
  assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_master
// Directed bench for ahb_bus_master: a per-cycle vector table (single read,
// 4-beat write, 1 KB crossing, length/alignment normalisation, no accept in
// FIN) followed by hand-written grant-drop, ERROR and wait-state/reset
// sequences. Inputs change 1 ns after the rising edge, outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_bus_master;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LEN_W     = $clog2(MAX_BEATS + 1);
  localparam int          NVEC      = 22;

  logic hclk    = 1'b0;
  logic hresetn = 1'b0;

  always #5 hclk = ~hclk;

  ahb_bus_master_if #(.MAX_BEATS(MAX_BEATS), .ADDR_W(ADDR_W)) bus ();

  ahb_bus_master #(.MAX_BEATS(MAX_BEATS), .ADDR_W(ADDR_W)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] i_cv, i_cw, i_addr, i_len, i_g, i_rdy, i_resp, i_rdata, i_wv, i_wd;
    logic [31:0] e_crdy, e_breq, e_trans, e_haddr, e_hwr, e_wrdy, e_hwdata,
                 e_rv, e_rdata, e_done, e_err;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [31:0] cv, cw, addr, len, g, rdy, resp, rdata, wv, wd,
    input logic [31:0] crdy, breq, trans, haddr, hwr, wrdy, hwdata, rv, rd, dn, er);
    vec_t v;
    v.i_cv = cv;   v.i_cw = cw;    v.i_addr = addr;   v.i_len = len;
    v.i_g = g;     v.i_rdy = rdy;  v.i_resp = resp;   v.i_rdata = rdata;
    v.i_wv = wv;   v.i_wd = wd;
    v.e_crdy = crdy;   v.e_breq = breq;    v.e_trans = trans;  v.e_haddr = haddr;
    v.e_hwr = hwr;     v.e_wrdy = wrdy;    v.e_hwdata = hwdata;
    v.e_rv = rv;       v.e_rdata = rd;     v.e_done = dn;      v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_hbusreq"},   32'(bus.hbusreq),   32'd0);
    chk({tag, "_htrans"},    32'(bus.htrans),    32'd0);
    chk({tag, "_haddr"},     32'(bus.haddr),     32'd0);
    chk({tag, "_hwrite"},    32'(bus.hwrite),    32'd0);
    chk({tag, "_hsize"},     32'(bus.hsize),     32'd2);
    chk({tag, "_hburst"},    32'(bus.hburst),    32'd1);
    chk({tag, "_hwdata"},    32'(bus.hwdata),    32'd0);
    chk({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    chk({tag, "_rd_data"},   32'(bus.rd_data),   32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
  endtask

  task automatic apply_row(input vec_t v);
    bus.cmd_valid = v.i_cv[0];
    bus.cmd_write = v.i_cw[0];
    bus.cmd_addr  = v.i_addr;
    bus.cmd_len   = LEN_W'(v.i_len);
    bus.hgrant    = v.i_g[0];
    bus.hready    = v.i_rdy[0];
    bus.hresp     = v.i_resp[0];
    bus.hrdata    = v.i_rdata;
    bus.wr_valid  = v.i_wv[0];
    bus.wr_data   = v.i_wd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d_cmd_ready", i), 32'(bus.cmd_ready), v.e_crdy);
    chk($sformatf("r%0d_hbusreq", i),   32'(bus.hbusreq),   v.e_breq);
    chk($sformatf("r%0d_htrans", i),    32'(bus.htrans),    v.e_trans);
    chk($sformatf("r%0d_haddr", i),     32'(bus.haddr),     v.e_haddr);
    chk($sformatf("r%0d_hwrite", i),    32'(bus.hwrite),    v.e_hwr);
    chk($sformatf("r%0d_wr_ready", i),  32'(bus.wr_ready),  v.e_wrdy);
    chk($sformatf("r%0d_hwdata", i),    32'(bus.hwdata),    v.e_hwdata);
    chk($sformatf("r%0d_rd_valid", i),  32'(bus.rd_valid),  v.e_rv);
    chk($sformatf("r%0d_rd_data", i),   32'(bus.rd_data),   v.e_rdata);
    chk($sformatf("r%0d_done", i),      32'(bus.done),      v.e_done);
    chk($sformatf("r%0d_err", i),       32'(bus.err),       v.e_err);
  endtask

  // Command cycle (cycle 0): present the command and confirm cmd_ready
  task automatic start_cmd(input logic w, input logic [31:0] addr, input int len, input string tag);
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LEN_W'(len);
    @(negedge hclk);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdq[$];
    logic [31:0] gd_exp [4];
    int          done_cyc;
    int          rv_cnt;
    logic        err_at_done;

    //          cv cw addr    len g  r  rs rdata          wv wd      crdy breq tr  haddr  hw wr hwdata rv rdata          dn er
    vecs[0]  = mk(1, 0, 'h100, 1, 1, 1, 0, 0,             0, 0,      1, 0, 0, 'h000, 0, 0, 0,     0, 0,             0, 0);
    vecs[1]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 1, 2, 'h100, 0, 0, 0,     0, 0,             0, 0);
    vecs[2]  = mk(0, 0, 0,     0, 1, 1, 0, 'hA5A5_0001,   0, 0,      0, 0, 0, 'h104, 0, 0, 0,     0, 0,             0, 0);
    vecs[3]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 0, 0, 'h104, 0, 0, 0,     1, 'hA5A5_0001,   1, 0);
    vecs[4]  = mk(1, 1, 'h200, 4, 1, 1, 0, 0,             1, 1,      1, 0, 0, 'h104, 0, 0, 0,     0, 'hA5A5_0001,   0, 0);
    vecs[5]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 1,      0, 1, 2, 'h200, 1, 1, 0,     0, 'hA5A5_0001,   0, 0);
    vecs[6]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 2,      0, 1, 3, 'h204, 1, 1, 1,     0, 'hA5A5_0001,   0, 0);
    vecs[7]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 3,      0, 1, 3, 'h208, 1, 1, 2,     0, 'hA5A5_0001,   0, 0);
    vecs[8]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 4,      0, 1, 3, 'h20C, 1, 1, 3,     0, 'hA5A5_0001,   0, 0);
    vecs[9]  = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 5,      0, 0, 0, 'h210, 1, 0, 4,     0, 'hA5A5_0001,   0, 0);
    vecs[10] = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 0, 0, 'h210, 1, 0, 4,     0, 'hA5A5_0001,   1, 0);
    vecs[11] = mk(1, 1, 'h3F8, 3, 1, 1, 0, 0,             0, 0,      1, 0, 0, 'h210, 1, 0, 4,     0, 'hA5A5_0001,   0, 0);
    vecs[12] = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 'h11,   0, 1, 2, 'h3F8, 1, 1, 4,     0, 'hA5A5_0001,   0, 0);
    vecs[13] = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 'h22,   0, 1, 3, 'h3FC, 1, 1, 'h11, 0, 'hA5A5_0001,   0, 0);
    vecs[14] = mk(0, 0, 0,     0, 1, 1, 0, 0,             1, 'h33,   0, 1, 2, 'h400, 1, 1, 'h22, 0, 'hA5A5_0001,   0, 0);
    vecs[15] = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 0, 0, 'h404, 1, 0, 'h33, 0, 'hA5A5_0001,   0, 0);
    vecs[16] = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 0, 0, 'h404, 1, 0, 'h33, 0, 'hA5A5_0001,   1, 0);
    vecs[17] = mk(1, 0, 'h503, 0, 1, 1, 0, 0,             0, 0,      1, 0, 0, 'h404, 1, 0, 'h33, 0, 'hA5A5_0001,   0, 0);
    vecs[18] = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      0, 1, 2, 'h500, 0, 0, 'h33, 0, 'hA5A5_0001,   0, 0);
    vecs[19] = mk(0, 0, 0,     0, 1, 1, 0, 'hDEAD_0002,   0, 0,      0, 0, 0, 'h504, 0, 0, 'h33, 0, 'hA5A5_0001,   0, 0);
    vecs[20] = mk(1, 1, 'h900, 2, 1, 1, 0, 0,             0, 0,      0, 0, 0, 'h504, 0, 0, 'h33, 1, 'hDEAD_0002,   1, 0);
    vecs[21] = mk(0, 0, 0,     0, 1, 1, 0, 0,             0, 0,      1, 0, 0, 'h504, 0, 0, 'h33, 0, 'hDEAD_0002,   0, 0);

    gd_exp[0] = 32'hB000_0002;
    gd_exp[1] = 32'hB000_0003;
    gd_exp[2] = 32'hB000_0005;
    gd_exp[3] = 32'hB000_0006;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.hgrant    = 1'b0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;

    // Reset values
    @(negedge hclk);
    check_reset("reset");
    @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);

    // Table-driven cycles
    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      v = vecs[i];
      tick();
      apply_row(v);
      @(negedge hclk);
      check_row(i, v);
    end

    // Grant drop in cycle 3 of a 4-beat read
    start_cmd(1'b0, 32'h600, 4, "gd");
    done_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.hgrant    = (c != 3);
      bus.hready    = 1'b1;
      bus.hresp     = 1'b0;
      bus.hrdata    = 32'hB000_0000 | 32'(c);
      @(negedge hclk);
      if (c == 3) begin
        chk("gd_idle_trans", 32'(bus.htrans), 32'd0);
        chk("gd_hbusreq_held", 32'(bus.hbusreq), 32'd1);
      end
      if (c == 4) begin
        chk("gd_resume_trans", 32'(bus.htrans), 32'd2);
        chk("gd_resume_addr", bus.haddr, 32'h608);
      end
      if (c == 5) chk("gd_last_trans", 32'(bus.htrans), 32'd3);
      if (bus.rd_valid) rdq.push_back(bus.rd_data);
      if (bus.done && done_cyc == 0) done_cyc = c;
    end
    chk("gd_rd_count", 32'(rdq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rdq.size()) chk($sformatf("gd_rd_data%0d", i), rdq[i], gd_exp[i]);
    end
    chk("gd_done_cycle", 32'(done_cyc), 32'd7);

    // Slave ERROR on the second beat of a 4-beat read
    start_cmd(1'b0, 32'h700, 4, "er");
    done_cyc    = 0;
    rv_cnt      = 0;
    err_at_done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.hgrant    = 1'b1;
      bus.hresp     = (c == 3) || (c == 4);
      bus.hready    = (c != 3);
      bus.hrdata    = 32'hC000_0000 | 32'(c);
      @(negedge hclk);
      if (c == 3) chk("er_cancel_trans", 32'(bus.htrans), 32'd0);
      if (c == 4) chk("er_second_trans", 32'(bus.htrans), 32'd0);
      if (bus.rd_valid) rv_cnt++;
      if (bus.done && done_cyc == 0) begin
        done_cyc    = c;
        err_at_done = bus.err;
      end
    end
    chk("er_rd_count", 32'(rv_cnt), 32'd1);
    chk("er_done_cycle", 32'(done_cyc), 32'd5);
    chk("er_err_flag", 32'(err_at_done), 32'd1);

    // Wait states on a write burst, then reset mid-burst
    start_cmd(1'b1, 32'h800, 4, "ws");
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.hgrant    = 1'b1;
      bus.hresp     = 1'b0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = (c == 1) ? 32'hA0 : ((c <= 5) ? 32'hA1 : 32'hA2);
      bus.hready    = !((c >= 2) && (c <= 4));
      @(negedge hclk);
      if ((c >= 2) && (c <= 5)) begin
        chk($sformatf("ws_trans_c%0d", c), 32'(bus.htrans), 32'd3);
        chk($sformatf("ws_addr_c%0d", c), bus.haddr, 32'h804);
        chk($sformatf("ws_hwdata_c%0d", c), bus.hwdata, 32'hA0);
      end
      if ((c >= 2) && (c <= 4)) chk($sformatf("ws_wr_ready_c%0d", c), 32'(bus.wr_ready), 32'd0);
      if (c == 5) chk("ws_wr_ready_c5", 32'(bus.wr_ready), 32'd1);
      if (c == 6) begin
        chk("ws_addr_c6", bus.haddr, 32'h808);
        chk("ws_hwdata_c6", bus.hwdata, 32'hA1);
      end
    end
    #1 hresetn = 1'b0;
    #1;
    check_reset("rst_mid");
    @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check_reset("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
